traffic_light_ctrl_multi: RTL and testbench

TRAFFIC_LIGHT_CTRL_MULTI -- requirements
Module: traffic_light_ctrl_multi

---
 rtl/traffic_light_ctrl_multi.sv | 119 +++++++++++
 tb/tb_traffic_light_ctrl_multi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_multi.sv
// Highway / multi-local-road traffic light controller.
// Moore FSM with one shared state counter, round-robin grant among local roads and registered lamps.
module traffic_light_ctrl_multi #(
  parameter int NUM_LR       = 2,
  parameter int HW_GREEN_MIN = 70,
  parameter int LR_GREEN_T   = 25,
  parameter int YELLOW_T     = 15,
  parameter int ALL_RED_T    = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_LR-1:0]                             lr_has_car,
  output logic [2:0]                                    hw_light,
  output logic [3*NUM_LR-1:0]                           lr_light,
  output logic [((NUM_LR > 1) ? $clog2(NUM_LR) : 1)-1:0] lr_sel
);

  localparam int SEL_W  = (NUM_LR > 1) ? $clog2(NUM_LR) : 1;
  localparam int MAX_AB = (HW_GREEN_MIN > LR_GREEN_T) ? HW_GREEN_MIN : LR_GREEN_T;
  localparam int MAX_CD = (YELLOW_T > ALL_RED_T) ? YELLOW_T : ALL_RED_T;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] HW_MIN_LAST = CNT_W'(HW_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] LR_G_LAST   = CNT_W'(LR_GREEN_T - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED_T - 1);

  localparam logic [2:0] GREEN  = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b001;

  typedef enum logic [2:0] {HW_G, HW_Y, AR1, LR_G, LR_Y, AR2} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [SEL_W-1:0]    sel_nxt, rr_pick;
  logic [2:0]          hw_nxt;
  logic [3*NUM_LR-1:0] lr_nxt;
  logic                rr_found;
  logic [NUM_LR-1:0]   rr_rot;
  int unsigned         rr_idx;

  function automatic logic [3*NUM_LR-1:0] lr_lamps(input state_t s, input logic [SEL_W-1:0] sel);
    logic [3*NUM_LR-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_LR; i++) begin
      v[3*i +: 3] = RED;
      if (32'(sel) == i) begin
        if (s == LR_G)      v[3*i +: 3] = GREEN;
        else if (s == LR_Y) v[3*i +: 3] = YELLOW;
      end
    end
    return v;
  endfunction

  // First requesting road scanning from lr_sel+1, wrapping back to lr_sel itself last.
  always_comb begin
    rr_pick  = lr_sel;
    rr_found = 1'b0;
    rr_rot   = '0;
    rr_idx   = 0;
    for (int unsigned k = 1; k <= NUM_LR; k++) begin
      rr_idx = (32'(lr_sel) + k) % NUM_LR;
      rr_rot = lr_has_car >> rr_idx;
      if (!rr_found && rr_rot[0]) begin
        rr_pick  = SEL_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    sel_nxt   = lr_sel;
    unique case (state)
      HW_G: if (cnt == HW_MIN_LAST) begin
        cnt_nxt = cnt;
        if (|lr_has_car) begin
          state_nxt = HW_Y;
          cnt_nxt   = '0;
          sel_nxt   = rr_pick;
        end
      end
      HW_Y: if (cnt == YEL_LAST)  begin state_nxt = AR1;  cnt_nxt = '0; end
      AR1:  if (cnt == AR_LAST)   begin state_nxt = LR_G; cnt_nxt = '0; end
      LR_G: if (cnt == LR_G_LAST) begin state_nxt = LR_Y; cnt_nxt = '0; end
      LR_Y: if (cnt == YEL_LAST)  begin state_nxt = AR2;  cnt_nxt = '0; end
      AR2:  if (cnt == AR_LAST)   begin state_nxt = HW_G; cnt_nxt = '0; end
      default: begin state_nxt = HW_G; cnt_nxt = '0; end
    endcase
  end

  // Lamps are decoded from the next state so the registered outputs track the state register.
  always_comb begin
    hw_nxt = RED;
    if (state_nxt == HW_G)      hw_nxt = GREEN;
    else if (state_nxt == HW_Y) hw_nxt = YELLOW;
    lr_nxt = lr_lamps(state_nxt, sel_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HW_G;
      cnt      <= '0;
      lr_sel   <= '0;
      hw_light <= GREEN;
      lr_light <= {NUM_LR{RED}};
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lr_sel   <= sel_nxt;
      hw_light <= hw_nxt;
      lr_light <= lr_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl_multi.sv
// Self-checking bench for traffic_light_ctrl_multi: schedule-queue reference model,
// per-cycle comparison and safety invariants, directed scenarios plus random traffic.
module tb_traffic_light_ctrl_multi;

  localparam int N   = 3;
  localparam int HGM = 4;
  localparam int LGT = 3;
  localparam int YT  = 2;
  localparam int ART = 1;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;
  localparam logic [8:0] ALL_R = {R, R, R};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] lr_has_car = '0;
  logic [2:0] hw_light;
  logic [8:0] lr_light;
  logic [1:0] lr_sel;

  int checks = 0;
  int failures = 0;

  traffic_light_ctrl_multi #(
    .NUM_LR(N), .HW_GREEN_MIN(HGM), .LR_GREEN_T(LGT), .YELLOW_T(YT), .ALL_RED_T(ART)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lr_has_car(lr_has_car),
    .hw_light(hw_light), .lr_light(lr_light), .lr_sel(lr_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] lr_field(input int sel, input logic [2:0] lamp);
    logic [8:0] v;
    v = ALL_R;
    v[3*sel +: 3] = lamp;
    return v;
  endfunction

  // Reference model: while the highway is green it counts elapsed green cycles; a grant
  // expands the whole fixed lamp sequence into a queue which is then replayed cycle by cycle.
  logic [11:0] sched[$];
  logic [2:0]  m_hw = G;
  logic [8:0]  m_lr = ALL_R;
  int          m_sel = 0;
  int          m_elapsed = 0;

  always @(posedge clk or negedge rst_n) begin
    logic       found;
    logic [2:0] sh;
    if (!rst_n) begin
      sched.delete();
      m_hw = G; m_lr = ALL_R; m_sel = 0; m_elapsed = 0;
    end else begin
      if (sched.size() == 0) begin
        if (m_elapsed >= HGM - 1 && |lr_has_car) begin
          found = 1'b0;
          for (int k = 1; k <= N; k++) begin
            sh = lr_has_car >> ((m_sel + k) % N);
            if (!found && sh[0]) begin
              m_sel = (m_sel + k) % N;
              found = 1'b1;
            end
          end
          repeat (YT)  sched.push_back({Y, ALL_R});
          repeat (ART) sched.push_back({R, ALL_R});
          repeat (LGT) sched.push_back({R, lr_field(m_sel, G)});
          repeat (YT)  sched.push_back({R, lr_field(m_sel, Y)});
          repeat (ART) sched.push_back({R, ALL_R});
          sched.push_back({G, ALL_R});
          {m_hw, m_lr} = sched.pop_front();
        end else begin
          m_elapsed++;
        end
      end else begin
        {m_hw, m_lr} = sched.pop_front();
        if (sched.size() == 0) m_elapsed = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic ok_hot;
    logic lr_green;
    int   non_red;
    check("hw_light", 32'(hw_light), 32'(m_hw));
    check("lr_light", 32'(lr_light), 32'(m_lr));
    check("lr_sel", 32'(lr_sel), 32'(m_sel));
    ok_hot = $onehot(hw_light);
    lr_green = 1'b0;
    non_red = 0;
    for (int i = 0; i < N; i++) begin
      ok_hot = ok_hot & $onehot(lr_light[3*i +: 3]);
      if (lr_light[3*i +: 3] != R) non_red++;
      if (lr_light[3*i + 2]) lr_green = 1'b1;
    end
    check("onehot", 32'(ok_hot), 32'(1));
    check("green_conflict", 32'(hw_light[2] && lr_green), 32'(0));
    check("one_lr_active", 32'(non_red <= 1), 32'(1));
  end

  logic [2:0] hw_log[0:63];
  logic [8:0] lr_log[0:63];
  logic [1:0] sel_log[0:63];

  task automatic tick(input int k);
    @(negedge clk); #1;
    hw_log[k] = hw_light;
    lr_log[k] = lr_light;
    sel_log[k] = lr_sel;
  endtask

  task automatic run_from(input int a, input int b);
    for (int k = a; k <= b; k++) tick(k);
  endtask

  task automatic reset_pulse(input logic [2:0] req);
    rst_n = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    lr_has_car = req;
    rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_hw", 32'(hw_light), 32'(G));
    check("rst_lr", 32'(lr_light), 32'(ALL_R));
    check("rst_sel", 32'(lr_sel), 32'(0));
    rst_n = 1'b1;

    // No requests: highway stays green.
    run_from(1, 50);
    check("idle_hw", 32'(hw_log[50]), 32'(G));
    check("idle_lr", 32'(lr_log[50]), 32'(ALL_R));

    // Road 0 held: 13-cycle period.
    reset_pulse(3'b001);
    run_from(1, 30);
    check("p0_hw_g3", 32'(hw_log[3]), 32'(G));
    check("p0_hw_y4", 32'(hw_log[4]), 32'(Y));
    check("p0_hw_y5", 32'(hw_log[5]), 32'(Y));
    check("p0_ar1", 32'({hw_log[6], lr_log[6]}), 32'({R, ALL_R}));
    check("p0_lg7", 32'(lr_log[7]), 32'({R, R, G}));
    check("p0_lg9", 32'(lr_log[9]), 32'({R, R, G}));
    check("p0_ly10", 32'(lr_log[10]), 32'({R, R, Y}));
    check("p0_ly11", 32'(lr_log[11]), 32'({R, R, Y}));
    check("p0_ar2", 32'({hw_log[12], lr_log[12]}), 32'({R, ALL_R}));
    check("p0_hw_g13", 32'(hw_log[13]), 32'(G));
    check("p0_hw_y17", 32'(hw_log[17]), 32'(Y));
    check("p0_sel17", 32'(sel_log[17]), 32'(0));

    // All roads held: grants rotate 1,2,0,1.
    reset_pulse(3'b111);
    run_from(1, 50);
    check("rr_sel3", 32'(sel_log[3]), 32'(0));
    check("rr_sel4", 32'(sel_log[4]), 32'(1));
    check("rr_sel17", 32'(sel_log[17]), 32'(2));
    check("rr_sel30", 32'(sel_log[30]), 32'(0));
    check("rr_sel43", 32'(sel_log[43]), 32'(1));
    check("rr_lg7", 32'(lr_log[7]), 32'({R, G, R}));
    check("rr_lg20", 32'(lr_log[20]), 32'({G, R, R}));
    check("rr_lg33", 32'(lr_log[33]), 32'({R, R, G}));

    // Single-cycle pulse on road 2 after a long green.
    reset_pulse(3'b000);
    run_from(1, 10);
    lr_has_car = 3'b100;
    tick(11);
    lr_has_car = 3'b000;
    run_from(12, 25);
    check("pulse_hw10", 32'(hw_log[10]), 32'(G));
    check("pulse_hw11", 32'(hw_log[11]), 32'(Y));
    check("pulse_sel11", 32'(sel_log[11]), 32'(2));
    check("pulse_lg14", 32'(lr_log[14]), 32'({G, R, R}));
    check("pulse_ly17", 32'(lr_log[17]), 32'({Y, R, R}));
    check("pulse_hw20", 32'(hw_log[20]), 32'(G));
    check("pulse_hw25", 32'(hw_log[25]), 32'(G));

    // Asynchronous reset in the middle of local green.
    reset_pulse(3'b001);
    run_from(1, 8);
    check("ar_pre_lg8", 32'(lr_log[8]), 32'({R, R, G}));
    rst_n = 1'b0;
    #2;
    check("ar_async_hw", 32'(hw_light), 32'(G));
    check("ar_async_lr", 32'(lr_light), 32'(ALL_R));
    check("ar_async_sel", 32'(lr_sel), 32'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_from(1, 6);
    check("ar_post_g3", 32'(hw_log[3]), 32'(G));
    check("ar_post_y4", 32'(hw_log[4]), 32'(Y));

    // Random traffic with occasional mid-cycle resets.
    reset_pulse(3'b000);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) lr_has_car = 3'b000;
        else lr_has_car = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
